// File: rtl/mlp_pkg.sv
// mlp_pkg
// Shared definitions for the MLP layer engine:
//   - host region select codes (SEL_IN, SEL_W, SEL_B, SEL_OUT)
//   - engine state encoding (IDLE, BIAS, MAC, ACT)
//   - saturate(): clamps a wide signed value to a w-bit signed range
// No ports (package).
package mlp_pkg;

    typedef enum logic [1:0] {
        SEL_IN  = 2'd0,
        SEL_W   = 2'd1,
        SEL_B   = 2'd2,
        SEL_OUT = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIAS = 2'd1,
        MAC  = 2'd2,
        ACT  = 2'd3
    } state_e;

    // Working width of saturate(); callers sign-extend into it, so any
    // accumulator up to 64 bits can be narrowed with the same function.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/mlp_activation.sv
// mlp_activation
// Purely combinational activation applied to one saturated neuron sum.
// Build option MLP_SIGMOID_EN:
//   defined     : hard sigmoid, clamp((s >>> 2) + 0.5, 0, 1.0) in Q(FRAC_W)
//   not defined : ReLU, max(s, 0)
// Ports:
//   s_i : signed DATA_W pre-activation value
//   y_o : signed DATA_W activated value
module mlp_activation #(
    parameter int DATA_W = 17,
    parameter int FRAC_W = 12
) (
    input  logic signed [DATA_W-1:0] s_i,
    output logic signed [DATA_W-1:0] y_o
);

`ifdef MLP_SIGMOID_EN
    // One extra bit so adding 0.5 to a large positive s cannot wrap.
    logic signed [DATA_W:0] t;
    logic signed [DATA_W:0] one;
    logic signed [DATA_W:0] half;

    always_comb begin
        one          = '0;
        one[FRAC_W]  = 1'b1;
        half         = '0;
        half[FRAC_W-1] = 1'b1;
        t            = {s_i[DATA_W-1], s_i >>> 2} + half;
        if (t[DATA_W]) begin
            y_o = '0;
        end else if (t > one) begin
            y_o = one[DATA_W-1:0];
        end else begin
            y_o = t[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        y_o = s_i[DATA_W-1] ? '0 : s_i;
    end
`endif

endmodule

// File: rtl/mlp_layer_engine.sv
// mlp_layer_engine
// Time-multiplexed fully connected layer: one shared signed MAC walks every
// neuron (BIAS -> N_IN x MAC -> ACT), then stores activated results for
// host readback. Activation flavour is chosen by build macro MLP_SIGMOID_EN
// (inside mlp_activation); timing is identical in both builds.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   we, sel, addr, wdata : host write (0=inputs, 1=weights j*N_IN+i,
//                          2=biases, 3=outputs read-only)
//   rdata        : registered read of (sel, addr), 1-cycle latency
//   start        : request evaluation (honoured only when idle)
//   busy, done   : evaluating / one-cycle completion pulse
module mlp_layer_engine
    import mlp_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int DATA_W = 17,
    parameter int FRAC_W = 12,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [1:0]        sel,
    input  logic [19:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              start,
    output logic              busy,
    output logic              done
);

    localparam int N_W  = N_OUT * N_IN;
    localparam int XA_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int WA_W = (N_W   > 1) ? $clog2(N_W)   : 1;
    localparam int OA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic signed [DATA_W-1:0] x_q   [N_IN];
    logic signed [DATA_W-1:0] w_q   [N_W];
    logic signed [DATA_W-1:0] b_q   [N_OUT];
    logic signed [DATA_W-1:0] out_q [N_OUT];

    state_e            state_q, state_d;
    logic              busy_q, done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [XA_W-1:0]   i_q;
    logic [OA_W-1:0]   j_q;
    logic [WA_W-1:0]   wp_q;   // flat weight pointer, equals j*N_IN + i
    logic              out_we;

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   s_act;
    logic signed [DATA_W-1:0]   act_y;

    logic in_ok, w_ok, b_ok, o_ok;

    always_comb begin
        in_ok = (addr < 20'(N_IN));
        w_ok  = (addr < 20'(N_W));
        b_ok  = (addr < 20'(N_OUT));
        o_ok  = (addr < 20'(N_OUT));
    end

    // Host-loaded storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && !busy_q) begin
            case (sel)
                SEL_IN:  if (in_ok) x_q[addr[XA_W-1:0]] <= wdata;
                SEL_W:   if (w_ok)  w_q[addr[WA_W-1:0]] <= wdata;
                SEL_B:   if (b_ok)  b_q[addr[OA_W-1:0]] <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (sel)
            SEL_IN:  if (in_ok) rdata_d = x_q[addr[XA_W-1:0]];
            SEL_W:   if (w_ok)  rdata_d = w_q[addr[WA_W-1:0]];
            SEL_B:   if (b_ok)  rdata_d = b_q[addr[OA_W-1:0]];
            default: if (o_ok)  rdata_d = out_q[addr[OA_W-1:0]];
        endcase
    end

    always_comb begin
        bias_ext = ACC_W'(b_q[j_q]);
        bias_ext = bias_ext <<< FRAC_W;
        prod     = w_q[wp_q] * x_q[i_q];
        s_act    = DATA_W'(saturate(SAT_W'(acc_q >>> FRAC_W), DATA_W));
    end

    mlp_activation #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_act (
        .s_i (s_act),
        .y_o (act_y)
    );

    // Next-state logic. A start coinciding with the done pulse is ignored,
    // so the host always sees done before a new run can begin.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        out_we  = 1'b0;
        case (state_q)
            IDLE: if (start && !done_q) state_d = BIAS;
            BIAS: state_d = MAC;
            MAC:  if (i_q == XA_W'(N_IN - 1)) state_d = ACT;
            ACT: begin
                out_we = 1'b1;
                if (j_q == OA_W'(N_OUT - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = BIAS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            wp_q    <= '0;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            rdata_q <= rdata_d;
            if (out_we) out_q[j_q] <= act_y;
            case (state_q)
                IDLE: begin
                    j_q  <= '0;
                    wp_q <= '0;
                end
                BIAS: i_q <= '0;
                MAC: begin
                    i_q  <= i_q + 1'b1;
                    wp_q <= wp_q + 1'b1;
                end
                ACT: j_q <= j_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Accumulator holds the full-precision sum; only ACT narrows it.
    always_ff @(posedge clk) begin
        case (state_q)
            BIAS:    acc_q <= bias_ext;
            MAC:     acc_q <= acc_q + ACC_W'(prod);
            default: ;
        endcase
    end

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mlp_layer_engine.sv
module tb_mlp_layer_engine;
    import mlp_pkg::*;

    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam int DATA_W = 17;
    localparam int FRAC_W = 12;
    localparam int ACC_W  = 40;

`ifdef MLP_SIGMOID_EN
    localparam int E_UNITY = 4096;
    localparam int E_ZERO  = 2048;
    localparam int E_NEG   = 0;
    localparam int E_SAT   = 4096;
`else
    localparam int E_UNITY = 8192;
    localparam int E_ZERO  = 0;
    localparam int E_NEG   = 0;
    localparam int E_SAT   = 65535;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              we;
    logic [1:0]        sel;
    logic [19:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              start;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    mlp_layer_engine #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .sel     (sel),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .start   (start),
        .busy    (busy),
        .done    (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic rd_issue = 1'b0;
    logic rd_vld_q = 1'b0;
    logic [DATA_W-1:0] exp_q [$];
    string name_q [$];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_vld_q <= rd_issue;
    end

    // Scoreboard monitor: a read issued last cycle is presented on rdata now.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        string n;
        if (rd_vld_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow got %0d want <expected entry>", rdata);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL %s got %0d want %0d", n, rdata, e);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] s, input int a, input int d);
        sel   = s;
        addr  = 20'(a);
        wdata = DATA_W'(d);
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input int a, input int e, input string n);
        sel  = s;
        addr = 20'(a);
        exp_q.push_back(DATA_W'(e));
        name_q.push_back(n);
        rd_issue = 1'b1;
        tick();
        rd_issue = 1'b0;
    endtask

    // Waits (bounded) for done; returns edges elapsed since t0.
    task automatic wait_done(input int t0, output int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        lat = cyc - t0;
    endtask

    task automatic run_layer(input string tag);
        int t0, lat, dc;
        dc = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        wait_done(t0, lat);
        chk({tag, "_latency"}, lat, 8);
        tick();
        chk({tag, "_one_done"}, done_cnt - dc, 1);
    endtask

    initial begin
        int t0, lat, dc;
        reset_n = 1'b0;
        we = 1'b0; start = 1'b0; sel = 2'd0; addr = '0; wdata = '0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rdata", int'(rdata), 0);
        reset_n = 1'b1;
        rd(SEL_OUT, 0, 0, "rst_out0");
        rd(SEL_OUT, 1, 0, "rst_out1");

        // Neuron 0: unity sum; neuron 1: negative sum.
        wr(SEL_IN, 0, 4096); wr(SEL_IN, 1, 4096);
        wr(SEL_W, 0, 4096); wr(SEL_W, 1, 4096);
        wr(SEL_W, 2, 4096); wr(SEL_W, 3, 4096);
        wr(SEL_B, 0, 0);    wr(SEL_B, 1, -20480);
        rd(SEL_W, 3, 4096, "w3_readback");
        rd(SEL_B, 1, -20480, "b1_readback");

        // Latency run with cycle-exact probes.
        start = 1'b1;
        tick();                   // edge k
        t0 = cyc;
        chk("busy_rise", int'(busy), 1);
        chk("done_early", int'(done), 0);
        tick();                   // edge k+1, start ignored while busy
        start = 1'b0;
        tick();                   // k+2
        tick();                   // k+3
        rd(SEL_OUT, 0, 0, "out0_before_act");   // sampled at k+4
        rd(SEL_OUT, 0, E_UNITY, "out0_after_act"); // sampled at k+5
        wait_done(t0, lat);
        chk("done_latency", lat, 8);
        chk("busy_fall_with_done", int'(busy), 0);
        start = 1'b1;
        tick();
        chk("start_on_done_ignored", int'(busy), 0);
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("start_after_done", int'(busy), 1);
        wait_done(t0, lat);
        chk("run2_latency", lat, 8);
        tick(); tick();
        chk("done_count", done_cnt, 2);
        rd(SEL_OUT, 0, E_UNITY, "unity_out0");
        rd(SEL_OUT, 1, E_NEG, "neg_out1");

        // Write protection.
        wr(SEL_OUT, 0, 1234);
        rd(SEL_OUT, 0, E_UNITY, "sel3_write_dropped");
        wr(SEL_IN, 5, 777);
        rd(SEL_IN, 5, 0, "x_oob_read");
        rd(SEL_IN, 1, 4096, "x1_after_oob_write");
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        wr(SEL_W, 0, 0);
        wait_done(t0, lat);
        chk("protect_latency", lat, 8);
        tick();
        rd(SEL_W, 0, 4096, "w0_busy_write_dropped");
        rd(SEL_OUT, 0, E_UNITY, "out0_busy_write");

        // Reset during MAC.
        dc = done_cnt;
        start = 1'b1;
        tick();                   // BIAS
        start = 1'b0;
        tick();                   // MAC
        reset_n = 1'b0;
        tick();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        reset_n = 1'b1;
        rd(SEL_OUT, 0, 0, "rst_mid_out0");
        rd(SEL_OUT, 1, 0, "rst_mid_out1");
        repeat (10) tick();
        chk("rst_mid_no_done", done_cnt - dc, 0);
        run_layer("rerun");
        rd(SEL_OUT, 0, E_UNITY, "rerun_out0");
        rd(SEL_OUT, 1, E_NEG, "rerun_out1");

        // Zero inputs.
        wr(SEL_IN, 0, 0); wr(SEL_IN, 1, 0);
        run_layer("zero");
        rd(SEL_OUT, 0, E_ZERO, "zero_out0");
        rd(SEL_OUT, 1, E_NEG, "zero_out1");

        // Positive and negative saturation.
        wr(SEL_IN, 0, 65535); wr(SEL_IN, 1, 65535);
        wr(SEL_W, 0, 65535);  wr(SEL_W, 1, 65535);
        wr(SEL_W, 2, -65536); wr(SEL_W, 3, -65536);
        wr(SEL_B, 0, 65535);  wr(SEL_B, 1, -65536);
        run_layer("sat");
        rd(SEL_OUT, 0, E_SAT, "sat_pos_out0");
        rd(SEL_OUT, 1, E_NEG, "sat_neg_out1");
        rd(SEL_OUT, 2, 0, "out_oob_read");

        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
